// File: rtl/servo_shadow_regs.sv
// servo_shadow_regs: double-buffered servo set-point registers.
// Writes land one channel at a time in a shadow bank; a commit moves every
// channel into the active bank on the same edge, optionally held off until the
// PWM period-boundary strobe, so downstream PWM never sees a mixed set.

// Per-channel slice: one shadow register, one active register, one dirty flag.
module servo_shadow_chan #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr,
    input  logic             xfer,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] active,
    output logic             dirty
);
    logic [WIDTH-1:0] shadow;

    // Shadow/active update; active takes the pre-edge shadow, so a write in a
    // transfer cycle lands in shadow only and keeps its dirty flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= RESET_VAL;
            active <= RESET_VAL;
            dirty  <= 1'b0;
        end else if (clr) begin
            shadow <= RESET_VAL;
            dirty  <= 1'b0;
        end else begin
            if (xfer)
                active <= shadow;
            if (wr) begin
                shadow <= wr_data;
                dirty  <= 1'b1;
            end else if (xfer) begin
                dirty  <= 1'b0;
            end
        end
    end
endmodule

module servo_shadow_regs #(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               IMMEDIATE = 0,
    localparam int              AW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      clr,
    input  logic                      commit,
    input  logic                      sync,
    output logic [CHANNELS*WIDTH-1:0] active_out,
    output logic [CHANNELS-1:0]       dirty,
    output logic                      pending,
    output logic                      committed
);
    logic                               addr_ok;
    logic                               wr_hit;
    logic                               xfer;
    logic [CHANNELS-1:0]                sel;
    logic [CHANNELS-1:0][WIDTH-1:0]     act;

    // Out-of-range addresses are dropped entirely; clr masks writes.
    assign addr_ok = ({1'b0, wr_addr} < (AW+1)'(CHANNELS));
    assign wr_hit  = wr_en & addr_ok & ~clr;

    // Transfer fires on commit directly in immediate mode, otherwise on the
    // first sync that sees an armed (or same-cycle) commit.
    assign xfer = ~clr & ((IMMEDIATE != 0) ? commit : ((pending | commit) & sync));

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_chan
            assign sel[k] = wr_hit & (wr_addr == AW'(k));

            servo_shadow_chan #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .clr     (clr),
                .wr      (sel[k]),
                .xfer    (xfer),
                .wr_data (wr_data),
                .active  (act[k]),
                .dirty   (dirty[k])
            );
        end
    endgenerate

    // Packed channel array flattens so channel k sits at [k*WIDTH +: WIDTH].
    assign active_out = act;

    // Arm/disarm: a commit consumed by a transfer does not re-arm, and
    // immediate mode never arms at all.
    always_ff @(posedge clk) begin
        if (reset)
            pending <= 1'b0;
        else if (clr || xfer || (IMMEDIATE != 0))
            pending <= 1'b0;
        else if (commit)
            pending <= 1'b1;
    end

    // One-cycle strobe aligned with the edge that updates active_out.
    always_ff @(posedge clk) begin
        if (reset)
            committed <= 1'b0;
        else
            committed <= xfer;
    end
endmodule

// File: tb/tb_servo_shadow_regs.sv
// Bench for servo_shadow_regs: table-driven run on the default configuration,
// plus hand sequences for a 3-channel instance and an immediate-mode instance.
module tb_servo_shadow_regs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default instance: WIDTH=8, CHANNELS=4, deferred commit
    logic        r0 = 1, we0 = 0, clr0 = 0, cm0 = 0, sy0 = 0;
    logic [1:0]  a0 = 0;
    logic [7:0]  d0 = 0;
    logic [31:0] act0;
    logic [3:0]  dty0;
    logic        pd0, cd0;

    servo_shadow_regs u0 (
        .clk(clk), .reset(r0), .wr_en(we0), .wr_addr(a0), .wr_data(d0),
        .clr(clr0), .commit(cm0), .sync(sy0),
        .active_out(act0), .dirty(dty0), .pending(pd0), .committed(cd0)
    );

    // Three channels: address 3 is out of range
    logic        r1 = 1, we1 = 0, clr1 = 0, cm1 = 0, sy1 = 0;
    logic [1:0]  a1 = 0;
    logic [7:0]  d1 = 0;
    logic [23:0] act1;
    logic [2:0]  dty1;
    logic        pd1, cd1;

    servo_shadow_regs #(.CHANNELS(3)) u1 (
        .clk(clk), .reset(r1), .wr_en(we1), .wr_addr(a1), .wr_data(d1),
        .clr(clr1), .commit(cm1), .sync(sy1),
        .active_out(act1), .dirty(dty1), .pending(pd1), .committed(cd1)
    );

    // Immediate mode, 12-bit channels
    logic        r2 = 1, we2 = 0, clr2 = 0, cm2 = 0, sy2 = 0;
    logic [1:0]  a2 = 0;
    logic [11:0] d2 = 0;
    logic [47:0] act2;
    logic [3:0]  dty2;
    logic        pd2, cd2;

    servo_shadow_regs #(.WIDTH(12), .IMMEDIATE(1)) u2 (
        .clk(clk), .reset(r2), .wr_en(we2), .wr_addr(a2), .wr_data(d2),
        .clr(clr2), .commit(cm2), .sync(sy2),
        .active_out(act2), .dirty(dty2), .pending(pd2), .committed(cd2)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic        rst, we, clr, cm, sy;
        logic [1:0]  a;
        logic [7:0]  d;
        logic [31:0] e_act;
        logic [3:0]  e_dty;
        logic        e_pd, e_cd;
        string       nm;
    } vec_t;

    vec_t vt[$];
    int   sb[$];

    function automatic void add(input logic rst, we, input logic [1:0] a, input logic [7:0] d,
                                input logic clr, cm, sy, input logic [31:0] e_act,
                                input logic [3:0] e_dty, input logic e_pd, e_cd, input string nm);
        vec_t v;
        v.rst = rst; v.we = we; v.a = a; v.d = d; v.clr = clr; v.cm = cm; v.sy = sy;
        v.e_act = e_act; v.e_dty = e_dty; v.e_pd = e_pd; v.e_cd = e_cd; v.nm = nm;
        vt.push_back(v);
    endfunction

    task automatic step1(input logic rst, we, input logic [1:0] a, input logic [7:0] d,
                         input logic clr, cm, sy);
        @(negedge clk);
        r1 = rst; we1 = we; a1 = a; d1 = d; clr1 = clr; cm1 = cm; sy1 = sy;
        @(posedge clk); #1;
    endtask

    task automatic step2(input logic rst, we, input logic [1:0] a, input logic [11:0] d,
                         input logic clr, cm, sy);
        @(negedge clk);
        r2 = rst; we2 = we; a2 = a; d2 = d; clr2 = clr; cm2 = cm; sy2 = sy;
        @(posedge clk); #1;
    endtask

    initial begin
        // rst we a d clr cm sy | active dirty pend comm
        add(1,0,0,8'h00,0,0,0, 32'h0,        4'b0000,0,0,"reset0");
        add(1,0,0,8'h00,0,0,0, 32'h0,        4'b0000,0,0,"reset1");
        add(0,0,0,8'h00,0,0,1, 32'h0,        4'b0000,0,0,"idle_sync0");
        add(0,0,0,8'h00,0,0,1, 32'h0,        4'b0000,0,0,"idle_sync1");
        add(0,1,0,8'h12,0,0,0, 32'h0,        4'b0001,0,0,"wr_ch0");
        add(0,1,3,8'hA5,0,0,0, 32'h0,        4'b1001,0,0,"wr_ch3");
        add(0,0,0,8'h00,0,1,0, 32'h0,        4'b1001,1,0,"commit");
        for (int i = 0; i < 4; i++)
            add(0,0,0,8'h00,0,0,0, 32'h0,    4'b1001,1,0,"wait_sync");
        add(0,0,0,8'h00,0,0,1, 32'hA5000012, 4'b0000,0,1,"xfer");
        add(0,0,0,8'h00,0,0,0, 32'hA5000012, 4'b0000,0,0,"post_xfer");
        add(0,1,1,8'h33,0,0,0, 32'hA5000012, 4'b0010,0,0,"wr_ch1");
        add(0,1,1,8'h7F,0,1,1, 32'hA5003312, 4'b0010,0,1,"simul");
        add(0,0,0,8'h00,0,1,1, 32'hA5007F12, 4'b0000,0,1,"b2b_xfer");
        add(0,0,0,8'h00,0,0,0, 32'hA5007F12, 4'b0000,0,0,"idle2");
        add(0,1,2,8'h44,0,1,0, 32'hA5007F12, 4'b0100,1,0,"wr_commit");
        add(0,0,0,8'h00,1,1,0, 32'hA5007F12, 4'b0000,0,0,"clr");
        add(0,0,0,8'h00,0,0,1, 32'hA5007F12, 4'b0000,0,0,"sync_after_clr");
        add(0,0,0,8'h00,0,1,1, 32'h0,        4'b0000,0,1,"xfer_cleared");
        add(0,1,0,8'h55,1,0,0, 32'h0,        4'b0000,0,0,"wr_during_clr");
        add(0,0,0,8'h00,0,1,1, 32'h0,        4'b0000,0,1,"xfer_no_wr");
        add(0,1,0,8'h11,0,0,0, 32'h0,        4'b0001,0,0,"wr_ch0b");
        add(0,0,0,8'h00,0,1,0, 32'h0,        4'b0001,1,0,"arm");
        add(0,0,0,8'h00,0,1,0, 32'h0,        4'b0001,1,0,"rearm");
        add(1,0,0,8'h00,0,0,0, 32'h0,        4'b0000,0,0,"reset_mid");
        add(0,0,0,8'h00,0,0,1, 32'h0,        4'b0000,0,0,"sync_after_reset");
        add(0,0,0,8'h00,0,1,1, 32'h0,        4'b0000,0,1,"xfer_after_reset");

        foreach (vt[i]) begin
            @(negedge clk);
            r0 = vt[i].rst; we0 = vt[i].we; a0 = vt[i].a; d0 = vt[i].d;
            clr0 = vt[i].clr; cm0 = vt[i].cm; sy0 = vt[i].sy;
            sb.push_back(i);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard_empty at vector %0d", i);
            end else begin
                int j;
                j = sb.pop_front();
                check({vt[j].nm, ".active"},    64'(act0), 64'(vt[j].e_act));
                check({vt[j].nm, ".dirty"},     64'(dty0), 64'(vt[j].e_dty));
                check({vt[j].nm, ".pending"},   64'(pd0),  64'(vt[j].e_pd));
                check({vt[j].nm, ".committed"}, 64'(cd0),  64'(vt[j].e_cd));
            end
        end

        // Three-channel instance: out-of-range write and clr
        step1(1,0,0,8'h00,0,0,0);
        step1(1,0,0,8'h00,0,0,0);
        step1(0,1,3,8'hFF,0,0,0);
        check("c3_oob.dirty",  64'(dty1), 64'h0);
        check("c3_oob.active", 64'(act1), 64'h0);
        step1(0,0,0,8'h00,0,1,1);
        check("c3_oob_xfer.active",    64'(act1), 64'h0);
        check("c3_oob_xfer.committed", 64'(cd1),  64'h1);
        step1(0,1,2,8'h44,0,0,0);
        check("c3_wr2.dirty", 64'(dty1), 64'h4);
        step1(0,0,0,8'h00,0,1,1);
        check("c3_xfer2.active", 64'(act1), 64'h440000);
        check("c3_xfer2.dirty",  64'(dty1), 64'h0);
        step1(0,1,2,8'h55,0,0,0);
        step1(0,0,0,8'h00,1,0,0);
        check("c3_clr.dirty",  64'(dty1), 64'h0);
        check("c3_clr.active", 64'(act1), 64'h440000);
        step1(0,0,0,8'h00,0,1,1);
        check("c3_clr_xfer.active",    64'(act1), 64'h0);
        check("c3_clr_xfer.committed", 64'(cd1),  64'h1);

        // Immediate-mode instance
        step2(1,0,0,12'h000,0,0,0);
        step2(1,0,0,12'h000,0,0,0);
        step2(0,1,1,12'hABC,0,0,0);
        check("imm_wr.dirty",  64'(dty2), 64'h2);
        check("imm_wr.active", 64'(act2), 64'h0);
        step2(0,0,0,12'h000,0,1,0);
        check("imm_xfer.active",    64'(act2), 64'h000000ABC000);
        check("imm_xfer.committed", 64'(cd2),  64'h1);
        check("imm_xfer.pending",   64'(pd2),  64'h0);
        check("imm_xfer.dirty",     64'(dty2), 64'h0);
        step2(0,0,0,12'h000,0,0,1);
        check("imm_idle.committed", 64'(cd2),  64'h0);
        check("imm_idle.pending",   64'(pd2),  64'h0);
        check("imm_idle.active",    64'(act2), 64'h000000ABC000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/servo_shadow_regs.md
# servo_shadow_regs

Parametrised, multi-channel, double-buffered holding register for servo set-points. Software- or FSM-side writes go one channel at a time into shadow registers. All channels are then moved atomically into the active outputs on a commit, qualified by a period-boundary strobe, so the PWM generators never see a half-updated set of values. It replaces the fixed 4-bit enable register: the width and channel count are parametrised, and it adds addressing, a commit/sync handshake and per-channel dirty tracking.

## Interface
Parameters:
- WIDTH, 8, bits per channel (>= 1)
- CHANNELS, 4, number of channels (>= 2)
- RESET_VAL, 0, value loaded into every shadow and active register on reset/clear
- IMMEDIATE, 0, 1 = transfer on the commit edge without waiting for sync; 0 = wait for sync

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe for the shadow register selected by wr_addr
- wr_addr  in  AW = max(1, clog2(CHANNELS))  channel select
- wr_data  in  WIDTH  data written to the shadow register
- clr  in  1  synchronous clear of the shadow side only
- commit  in  1  request to transfer shadow to active (single-cycle pulse or level)
- sync  in  1  period-boundary strobe from the PWM timebase
- active_out  out  CHANNELS*WIDTH  active values; channel k is at bits [k*WIDTH +: WIDTH]
- dirty  out  CHANNELS  per-channel flag: shadow written since the last transfer
- pending  out  1  a commit is armed and waiting for sync
- committed  out  1  one-cycle pulse; the active values changed on this clock edge

## Operation
- Reset (highest priority):
  - shadow[k] and active[k] load RESET_VAL.
  - dirty, pending and committed go to 0.
- clr (priority below reset):
  - shadow[k] loads RESET_VAL; dirty and pending go to 0.
  - active_out is unchanged.
  - wr_en and commit in the same cycle are ignored.
- Write:
  - wr_en=1 with wr_addr < CHANNELS loads shadow[wr_addr] with wr_data and sets dirty[wr_addr].
  - wr_addr >= CHANNELS is ignored: no register changes and no dirty bit is set.
- Arm: commit=1 sets pending. A repeated commit while pending is already set has no further effect.
- Transfer condition:
  - IMMEDIATE=0: (pending | commit) & sync.
  - IMMEDIATE=1: commit, and pending stays 0.
- Transfer (when the condition holds):
  - Every active[k] loads shadow[k], i.e. the value held before this edge.
  - pending clears and committed pulses high for one cycle.
  - All dirty bits clear, except the bit for a channel written in the same cycle.
- Write during a transfer cycle: that write is not part of the transfer. It lands in shadow and its dirty bit is set.
- sync with no commit armed and none present: no effect.
- Commits do not queue: a commit in the same cycle as a transfer is consumed by that transfer.

## Timing
- Write to shadow: 1 cycle. dirty is visible on the edge after wr_en.
- commit to pending: 1 cycle.
- Transfer edge:
  - active_out and committed change on the same edge, so committed=1 is aligned with the new active values.
  - committed drops on the next edge unless another transfer occurs.
- Worst-case commit-to-output latency (IMMEDIATE=0) is the wait until the next sync plus 1 cycle.
- All outputs are registered; there is no combinational path from input to output.
- Reset while pending: pending is dropped, active returns to RESET_VAL, and a later sync does nothing.

## Test plan
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then release.
  - Required: active_out all RESET_VAL (0), dirty=0, pending=0, committed=0.
  - Then sync pulses with no commit: outputs stay unchanged.
- Deferred commit (defaults):
  - Stimulus: write ch0=0x12, ch3=0xA5, giving dirty=4'b1001. Pulse commit, then sync 5 cycles later.
  - Required: pending=1 for those 5 cycles with active_out still 0.
  - After the sync edge: active ch0=0x12, ch3=0xA5, ch1/ch2=0, committed=1 for exactly 1 cycle, dirty=0, pending=0.
- Simultaneous events:
  - Stimulus: commit, sync and a write ch1=0x7F all in the same cycle, with shadow ch1=0x33 beforehand.
  - Required: active ch1=0x33 after the edge, shadow ch1=0x7F, dirty=4'b0010.
- Out-of-range address and clr:
  - Stimulus: with CHANNELS=3, write wr_addr=3 with data 0xFF.
  - Required: no change to any register and dirty=0.
  - Stimulus: write ch2=0x44, then assert clr.
  - Required: dirty=0, and the next commit+sync loads active ch2=RESET_VAL.
- IMMEDIATE=1, WIDTH=12:
  - Stimulus: write ch1=0xABC, then commit with sync=0.
  - Required: active ch1=0xABC on the next edge, committed pulses, pending stays 0.
- Reset mid-operation:
  - Stimulus: arm pending, assert reset, release, then pulse sync.
  - Required: no transfer and no committed pulse; active stays RESET_VAL.
